// File: rtl/dst_scoreboard_pkg.sv
// Shared sizing for the destination scoreboard and any pipeline control or
// hazard logic that needs to agree with it on register-index width and
// in-flight write depth.
//   NREG    : number of architectural registers (register 0 is hardwired zero)
//   REGW    : register-index width
//   CNTW    : per-register in-flight write counter width
//   CNT_MAX : saturation value of a counter; further writes must stall
//   reg_idx_t : register-index type
package dst_scoreboard_pkg;

    localparam int NREG    = 32;
    localparam int REGW    = 5;
    localparam int CNTW    = 2;
    localparam int CNT_MAX = (1 << CNTW) - 1;

    typedef logic [REGW-1:0] reg_idx_t;

endpackage

// File: rtl/dst_cnt.sv
// Per-register in-flight write counter.
//   clk     : block clock, rising edge
//   rst_n   : synchronous active-low reset, clears the count
//   inc     : one more write to this register was accepted at issue
//   dec     : one write to this register retired at writeback
//   count   : current number of issued-but-not-written-back writes
//   nonzero : count != 0
// The caller gates inc at saturation and dec at zero, so this block never
// has to guard against wrapping itself. Simultaneous inc and dec cancel.
module dst_cnt #(
    parameter int CNTW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc,
    input  logic            dec,
    output logic [CNTW-1:0] count,
    output logic            nonzero
);

    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec) begin
            cnt_d = cnt_q + CNTW'(1);
        end else if (dec && !inc) begin
            cnt_d = cnt_q - CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count   = cnt_q;
    assign nonzero = (cnt_q != '0);

endmodule

// File: rtl/dst_scoreboard.sv
// Destination-register scoreboard for an in-order issue stage.
// Tracks, per architectural register, how many writes have issued but not yet
// written back, and stalls issue on a read-after-write hazard or when the
// destination's counter is saturated.
//   clk           : block clock, rising edge
//   rst_n         : synchronous active-low reset
//   iss_valid     : instruction presented at issue
//   iss_rs/iss_rt : source register indices
//   iss_use_rs/rt : the corresponding source is actually read
//   iss_wr        : issuing instruction writes a destination
//   iss_dst       : destination index
//   wb_valid      : writeback to the register file this cycle
//   wb_dst        : writeback destination index
//   stall         : combinational; issue must hold its instruction
//   pending_any   : combinational; some register has an outstanding write
//   err_underflow : registered, sticky; writeback seen with no outstanding write
module dst_scoreboard
    import dst_scoreboard_pkg::*;
#(
    parameter int NREG = dst_scoreboard_pkg::NREG,
    parameter int REGW = dst_scoreboard_pkg::REGW,
    parameter int CNTW = dst_scoreboard_pkg::CNTW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iss_valid,
    input  logic [REGW-1:0] iss_rs,
    input  logic [REGW-1:0] iss_rt,
    input  logic            iss_use_rs,
    input  logic            iss_use_rt,
    input  logic            iss_wr,
    input  logic [REGW-1:0] iss_dst,
    input  logic            wb_valid,
    input  logic [REGW-1:0] wb_dst,
    output logic            stall,
    output logic            pending_any,
    output logic            err_underflow
);

    // Register 0 has no counter, so all per-register vectors start at 1.
    logic [NREG-1:1] nz_w;
    logic [NREG-1:1] sat_w;
    logic [NREG-1:1] inc_w;
    logic [NREG-1:1] dec_w;

    logic raw_rs;
    logic raw_rt;
    logic sat_dst;
    logic wb_hit;
    logic wb_nz;
    logic accept;
    logic underflow;

    logic err_underflow_q;
    logic err_underflow_d;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        logic [CNTW-1:0] count;

        dst_cnt #(
            .CNTW (CNTW)
        ) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc     (inc_w[r]),
            .dec     (dec_w[r]),
            .count   (count),
            .nonzero (nz_w[r])
        );

        assign sat_w[r] = (count == {CNTW{1'b1}});
    end

    // Hazard lookup uses only registered counts: a writeback landing in the
    // same cycle does not release a stalled reader until the next cycle.
    // Index 0 never matches because the loop starts at 1.
    always_comb begin
        raw_rs  = 1'b0;
        raw_rt  = 1'b0;
        sat_dst = 1'b0;
        wb_hit  = 1'b0;
        wb_nz   = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            if (iss_rs == REGW'(r)) begin
                raw_rs = iss_use_rs && nz_w[r];
            end
            if (iss_rt == REGW'(r)) begin
                raw_rt = iss_use_rt && nz_w[r];
            end
            if (iss_dst == REGW'(r)) begin
                sat_dst = iss_wr && sat_w[r];
            end
            if (wb_dst == REGW'(r)) begin
                wb_hit = 1'b1;
                wb_nz  = nz_w[r];
            end
        end
    end

    assign stall  = iss_valid && (raw_rs || raw_rt || sat_dst);
    assign accept = iss_valid && !stall;

    // Increment and decrement decode; the nonzero gate on dec keeps a stray
    // writeback from wrapping a counter, and the stall gate on inc keeps a
    // saturated counter from wrapping.
    always_comb begin
        inc_w = '0;
        dec_w = '0;
        for (int r = 1; r < NREG; r++) begin
            inc_w[r] = accept && iss_wr && (iss_dst == REGW'(r));
            dec_w[r] = wb_valid && (wb_dst == REGW'(r)) && nz_w[r];
        end
    end

    assign underflow = wb_valid && wb_hit && !wb_nz;

    always_comb begin
        err_underflow_d = err_underflow_q || underflow;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_underflow_q <= 1'b0;
        end else begin
            err_underflow_q <= err_underflow_d;
        end
    end

    assign err_underflow = err_underflow_q;
    assign pending_any   = |nz_w;

endmodule

// File: tb/tb_dst_scoreboard.sv
// Directed bench for dst_scoreboard: inputs change 1 time unit after the
// rising edge, outputs are checked 2 time units later.
module tb_dst_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       iss_valid;
    logic [4:0] iss_rs;
    logic [4:0] iss_rt;
    logic       iss_use_rs;
    logic       iss_use_rt;
    logic       iss_wr;
    logic [4:0] iss_dst;
    logic       wb_valid;
    logic [4:0] wb_dst;
    logic       stall;
    logic       pending_any;
    logic       err_underflow;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dst_scoreboard dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .iss_valid     (iss_valid),
        .iss_rs        (iss_rs),
        .iss_rt        (iss_rt),
        .iss_use_rs    (iss_use_rs),
        .iss_use_rt    (iss_use_rt),
        .iss_wr        (iss_wr),
        .iss_dst       (iss_dst),
        .wb_valid      (wb_valid),
        .wb_dst        (wb_dst),
        .stall         (stall),
        .pending_any   (pending_any),
        .err_underflow (err_underflow)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst_n      = 1'b0;
        iss_valid  = 1'b0;
        iss_rs     = '0;
        iss_rt     = '0;
        iss_use_rs = 1'b0;
        iss_use_rt = 1'b0;
        iss_wr     = 1'b0;
        iss_dst    = '0;
        wb_valid   = 1'b0;
        wb_dst     = '0;

        tick();
        tick();
        settle();
        chk("reset_stall", stall, 1'b0);
        chk("reset_pending", pending_any, 1'b0);
        chk("reset_err", err_underflow, 1'b0);
        rst_n = 1'b1;

        // RAW on r8, released one cycle after its writeback
        tick();
        iss_valid = 1'b1; iss_wr = 1'b1; iss_dst = 5'd8;
        settle();
        chk("r8_write_issue_stall", stall, 1'b0);
        tick();
        iss_wr = 1'b0; iss_use_rs = 1'b1; iss_rs = 5'd8;
        settle();
        chk("r8_raw_stall", stall, 1'b1);
        chk("r8_pending", pending_any, 1'b1);
        iss_valid = 1'b0;
        #1;
        chk("r8_no_valid_no_stall", stall, 1'b0);
        iss_valid = 1'b1; wb_valid = 1'b1; wb_dst = 5'd8;
        #1;
        chk("r8_same_cycle_wb_stall", stall, 1'b1);
        tick();
        wb_valid = 1'b0;
        settle();
        chk("r8_after_wb_stall", stall, 1'b0);
        chk("r8_after_wb_pending", pending_any, 1'b0);
        chk("r8_after_wb_err", err_underflow, 1'b0);
        iss_valid = 1'b0; iss_use_rs = 1'b0;

        // Saturation on r5
        iss_valid = 1'b1; iss_wr = 1'b1; iss_dst = 5'd5;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("r5_fill_stall", stall, 1'b0);
            tick();
        end
        settle();
        chk("r5_sat_stall", stall, 1'b1);
        tick();
        settle();
        chk("r5_sat_held_stall", stall, 1'b1);
        // Drain with three writebacks; a reader of r5 stalls until the last
        iss_wr = 1'b0; iss_use_rt = 1'b1; iss_rt = 5'd5;
        wb_valid = 1'b1; wb_dst = 5'd5;
        settle();
        chk("r5_cnt3_read_stall", stall, 1'b1);
        tick();
        settle();
        chk("r5_cnt2_read_stall", stall, 1'b1);
        tick();
        settle();
        chk("r5_cnt1_read_stall", stall, 1'b1);
        tick();
        wb_valid = 1'b0;
        settle();
        chk("r5_cnt0_read_stall", stall, 1'b0);
        chk("r5_drain_err", err_underflow, 1'b0);
        iss_valid = 1'b0; iss_use_rt = 1'b0;

        // Simultaneous inc and dec on r9 keeps count at 1
        iss_valid = 1'b1; iss_wr = 1'b1; iss_dst = 5'd9;
        settle();
        chk("r9_first_issue_stall", stall, 1'b0);
        tick();
        wb_valid = 1'b1; wb_dst = 5'd9;
        settle();
        chk("r9_inc_dec_stall", stall, 1'b0);
        tick();
        iss_wr = 1'b0; wb_valid = 1'b0; iss_use_rs = 1'b1; iss_rs = 5'd9;
        settle();
        chk("r9_pending_after_both", pending_any, 1'b1);
        chk("r9_read_stall", stall, 1'b1);
        wb_valid = 1'b1;
        tick();
        wb_valid = 1'b0;
        settle();
        chk("r9_single_wb_clears", stall, 1'b0);
        chk("r9_pending_clear", pending_any, 1'b0);
        chk("r9_err", err_underflow, 1'b0);
        iss_valid = 1'b0; iss_use_rs = 1'b0;

        // Self-dependency on r10 does not stall itself
        iss_valid = 1'b1; iss_wr = 1'b1; iss_dst = 5'd10;
        iss_use_rs = 1'b1; iss_rs = 5'd10; iss_use_rt = 1'b1; iss_rt = 5'd10;
        settle();
        chk("r10_self_dep_stall", stall, 1'b0);
        tick();
        iss_wr = 1'b0;
        settle();
        chk("r10_next_read_stall", stall, 1'b1);
        iss_valid = 1'b0; iss_use_rs = 1'b0; iss_use_rt = 1'b0;
        wb_valid = 1'b1; wb_dst = 5'd10;
        tick();
        wb_valid = 1'b0;
        settle();
        chk("r10_pending_clear", pending_any, 1'b0);

        // Register 0 is never tracked
        iss_valid = 1'b1; iss_use_rs = 1'b1; iss_rs = 5'd0;
        iss_wr = 1'b1; iss_dst = 5'd0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("r0_stall", stall, 1'b0);
            chk("r0_pending", pending_any, 1'b0);
            tick();
        end
        iss_valid = 1'b0; iss_use_rs = 1'b0; iss_wr = 1'b0;
        wb_valid = 1'b1; wb_dst = 5'd0;
        tick();
        wb_valid = 1'b0;
        settle();
        chk("r0_wb_err", err_underflow, 1'b0);

        // Underflow on r12 is sticky
        wb_valid = 1'b1; wb_dst = 5'd12;
        settle();
        chk("r12_err_not_yet", err_underflow, 1'b0);
        tick();
        wb_valid = 1'b0;
        settle();
        chk("r12_err_set", err_underflow, 1'b1);
        chk("r12_pending", pending_any, 1'b0);
        tick();
        settle();
        chk("r12_err_sticky", err_underflow, 1'b1);

        // Mid-operation reset with r3=2, r7=1
        iss_valid = 1'b1; iss_wr = 1'b1; iss_dst = 5'd3;
        tick();
        tick();
        iss_dst = 5'd7;
        tick();
        iss_wr = 1'b0; iss_use_rs = 1'b1; iss_rs = 5'd3;
        iss_use_rt = 1'b1; iss_rt = 5'd7;
        settle();
        chk("pre_reset_pending", pending_any, 1'b1);
        chk("pre_reset_stall", stall, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        chk("post_reset_stall", stall, 1'b0);
        chk("post_reset_pending", pending_any, 1'b0);
        chk("post_reset_err", err_underflow, 1'b0);
        iss_valid = 1'b0; iss_use_rs = 1'b0; iss_use_rt = 1'b0;
        wb_valid = 1'b1; wb_dst = 5'd3;
        tick();
        wb_valid = 1'b0;
        settle();
        chk("post_reset_wb_underflow", err_underflow, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dst_scoreboard.md
DST_SCOREBOARD -- requirements
Module: dst_scoreboard

Interface
REQ-001 Parameter NREG, default 32: number of architectural registers.
REQ-002 Parameter REGW, default 5: register-index width.
REQ-003 Parameter CNTW, default 2: per-register in-flight write counter width; CNT_MAX = 2^CNTW-1 = 3.
REQ-004 clk  input  1: the block's single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1: reset, synchronous and active-low.
REQ-006 iss_valid  input  1: an instruction is presented at issue.
REQ-007 iss_rs, iss_rt  input  REGW each: source register indices.
REQ-008 iss_use_rs, iss_use_rt  input  1 each: the corresponding source is actually read.
REQ-009 iss_wr  input  1: the issuing instruction writes a destination register.
REQ-010 iss_dst  input  REGW: destination index, i.e. the register later selected by the destination mux.
REQ-011 wb_valid  input  1: a writeback to the register file is occurring this cycle.
REQ-012 wb_dst  input  REGW: writeback destination index.
REQ-013 stall  output  1: combinational; the issue stage must hold its instruction.
REQ-014 pending_any  output  1: combinational; at least one counter is non-zero.
REQ-015 err_underflow  output  1: registered, sticky; a writeback arrived for a register with count 0.

Function
REQ-016 Each register r in 1..NREG-1 has a CNTW-bit counter cnt[r] holding its number of issued-but-not-written-back writes; register 0 has no counter and always reads as 0.
REQ-017 stall = iss_valid AND (RAW_rs OR RAW_rt OR SAT).
- RAW_rs = iss_use_rs AND iss_rs!=0 AND cnt[iss_rs]!=0.
- RAW_rt is defined the same way on iss_rt / iss_use_rt.
- SAT = iss_wr AND iss_dst!=0 AND cnt[iss_dst]==CNT_MAX.
REQ-018 stall uses the registered counter values only; a same-cycle writeback to a source register does not clear stall (no bypass); stall drops one cycle after that writeback.
REQ-019 Accept = iss_valid AND NOT stall; inc[r] = Accept AND iss_wr AND iss_dst==r AND r!=0.
REQ-020 dec[r] = wb_valid AND wb_dst==r AND r!=0 AND cnt[r]!=0.
REQ-021 Next cnt[r]:
- inc only: cnt+1.
- dec only: cnt-1.
- both or neither: unchanged.
REQ-022 cnt[r] never wraps: SAT blocks increments at CNT_MAX, and dec is gated to block decrements at 0.
REQ-023 wb_valid with wb_dst!=0 and cnt[wb_dst]==0 sets err_underflow at the next edge; the error holds until reset; counters are unchanged.
REQ-024 Writebacks or issues targeting register 0 have no effect and never raise err_underflow.
REQ-025 An instruction whose sources equal its own destination is checked against counts before its own increment; it does not stall on itself.
REQ-026 Latency: an accepted write is visible to stall in the next cycle; a writeback clears its pending state in the next cycle.
REQ-027 pending_any = OR over r of (cnt[r]!=0).

Reset
REQ-028 While rst_n=0 at a rising edge: all cnt[r] are set to 0, err_underflow to 0, and increments and decrements that cycle are discarded.
REQ-029 Consequence of REQ-028 during reset: stall equals only the SAT/RAW terms of zero counts, so it is 0; pending_any is 0.
REQ-030 A reset asserted mid-operation discards all in-flight tracking; writebacks arriving afterwards for those registers raise err_underflow per REQ-023.

Structure
REQ-031 A shared package holds NREG, REGW, CNTW and CNT_MAX, plus the register-index type, for reuse by the pipeline control and hazard logic.
REQ-032 The per-register counter (inputs inc/dec, outputs count and nonzero) is the sub-module dst_cnt, instantiated for r=1..NREG-1; the top holds the decode, the stall logic and the error flag.

Verification
REQ-033 Issue iss_wr=1, iss_dst=8, then the next cycle issue with iss_use_rs=1, iss_rs=8 -> stall=1; wb_valid=1, wb_dst=8 -> stall=1 in that cycle and 0 in the next; cnt[8]=0.
REQ-034 Three accepted writes to r5 with no writeback -> cnt[5]=3; a fourth issue iss_wr=1, iss_dst=5 -> stall=1 and cnt stays 3.
REQ-035 cnt[9]=1, then the same cycle: an accepted issue with iss_dst=9 and wb_valid with wb_dst=9 -> cnt[9]=1 unchanged and pending_any=1.
REQ-036 wb_valid=1, wb_dst=12 with cnt[12]=0 -> err_underflow=1 next cycle and it stays 1; wb_dst=0 leaves err_underflow=0.
REQ-037 iss_rs=0, iss_use_rs=1, iss_wr=1, iss_dst=0 repeated -> stall never asserts and pending_any=0.
REQ-038 cnt[3]=2 and cnt[7]=1, then rst_n=0 for one edge -> all counts 0, stall=0, pending_any=0, err_underflow=0.
